chan_mux_scan: RTL
==================

Name: chan_mux_scan

Overview:
- Parametrised, registered N-channel, W-bit multiplexer. Generalises the 4:1 single-bit mux.
- Two modes:
  - Manual: external select.
  - Scan: internal round-robin pointer with a programmable dwell per channel.
- Sits between parallel sensor/data lanes and a single serial consumer (display driver, UART framer).
- Output is registered and tagged with the channel index and a valid flag.

Parameters:
- WIDTH, 8, data bits per channel (>=1)
- CHANNELS, 4, number of input channels (>=2)
- SEL_W, $clog2(CHANNELS), select/index width (derived, not overridden)
- DWELL, 1, consecutive enabled cycles spent on each channel in scan mode (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in  input  CHANNELS*WIDTH  flattened channel data; channel k = in[k*WIDTH +: WIDTH]
- sel  input  SEL_W  channel select, used in manual mode only
- mode  input  1  0 = manual, 1 = scan
- en  input  1  advance/sample enable
- q  output  WIDTH  selected channel data, registered
- q_ch  output  SEL_W  index of the channel currently in q
- q_valid  output  1  q/q_ch hold a fresh sample this cycle
- wrap  output  1  one-cycle pulse: scan pointer wrapped CHANNELS-1 -> 0

Behaviour:
- Reset:
  - Synchronous; sampled on the clk rising edge while rst_n=0.
  - q=0, q_ch=0, q_valid=0, wrap=0.
  - Internal ptr=0, dwell counter dcnt=0, mode_d=0.
  - Reset mid-scan discards pointer state; scanning restarts at channel 0.
- Latency: 1 cycle. A sample taken at edge n appears on q/q_ch/q_valid after edge n.
- en=0:
  - q and q_ch hold their values.
  - q_valid=0, wrap=0.
  - ptr and dcnt frozen.
- Manual mode (mode=0, en=1):
  - q <= channel[sel], q_ch <= sel, q_valid <= 1.
  - If sel >= CHANNELS (non-power-of-2 CHANNELS): q <= 0, q_ch <= sel, q_valid <= 0.
  - ptr and dcnt are not modified in manual mode.
- Scan mode (mode=1, en=1):
  - q <= channel[ptr], q_ch <= ptr, q_valid <= 1; sel is ignored.
  - If dcnt == DWELL-1: dcnt <= 0 and ptr advances.
    - ptr == CHANNELS-1 -> ptr <= 0 and wrap <= 1 (same edge as the final sample of channel CHANNELS-1).
    - Otherwise ptr <= ptr+1.
  - Else dcnt <= dcnt+1.
  - wrap is 0 in every other cycle.
- Mode change:
  - mode_d registers the previous mode.
  - On the first enabled cycle with mode=1 and mode_d=0, the scan starts at ptr=0, dcnt=0: that cycle samples channel 0 and counts as dwell cycle 0.
  - Leaving scan mode takes effect on the next enabled cycle with no extra latency.
- Width rules:
  - dcnt width = max(1, $clog2(DWELL)).
  - With DWELL=1, ptr advances on every enabled cycle.
- Boundary: CHANNELS=2, DWELL=1 toggles the channel every enabled cycle; wrap pulses every second enabled cycle.

Optional Feature:
- Macro CHAN_MUX_PARITY_EN.
- Defined: adds output q_par (1 bit).
  - q_par is registered with q and equals the XOR of the selected channel data (even parity).
  - Cleared to 0 on reset; holds when en=0.
  - Forced to 0 when the manual select is out of range.
- Undefined: the q_par port and its logic do not exist. All other behaviour is identical.

Test Plan:
- Reset check: WIDTH=8, CHANNELS=4; hold rst_n=0 for 3 cycles with in/en toggling -> q=0, q_ch=0, q_valid=0, wrap=0 throughout.
- Manual select: in = {8'hD4, 8'hC3, 8'hB2, 8'hA1}, mode=0, en=1, sel 0,1,2,3 on consecutive cycles -> one cycle later q = A1, B2, C3, D4 with q_ch = 0..3 and q_valid=1; en=0 -> q holds D4 and q_valid=0.
- Scan with dwell: DWELL=2, same inputs, mode=1, en=1 for 8 cycles -> q sequence A1,A1,B2,B2,C3,C3,D4,D4; wrap=1 only alongside the second D4; the 9th sample is A1.
- Enable gap mid-scan: DWELL=1, en pattern 1,1,0,0,1 -> samples A1, B2, then hold B2 with q_valid=0, then C3; no channel is skipped.
- Mode switch and out-of-range select: CHANNELS=3, manual sel=3 -> q=0, q_valid=0; switch manual -> scan while the manual sel=2 -> first scan sample is channel 0; synchronous reset asserted mid-scan -> next scan after reset starts at channel 0.
- Parity (with CHAN_MUX_PARITY_EN defined): channel data 8'hA1 -> q_par=1; 8'hC3 -> q_par=0.

Source files
------------

// File: rtl/chan_mux_scan_if.sv
// ---------------------------------------------------------------------------
// chan_mux_scan_if
//
// Purpose:
//    Bundles the data lanes, channel controls and tagged output of the
//    chan_mux_scan block so producer and consumer can be wired with one
//    connection.
//
// Parameters:
//    WIDTH     data bits per channel
//    CHANNELS  number of input channels (SEL_W is derived from it)
//
// Signals:
//    in       CHANNELS*WIDTH  flattened channel data, channel k = in[k*WIDTH +: WIDTH]
//    sel      SEL_W           manual channel select
//    mode     1               0 = manual, 1 = scan
//    en       1               advance/sample enable
//    q        WIDTH           registered selected data
//    q_ch     SEL_W           channel index currently held in q
//    q_valid  1               q/q_ch carry a fresh sample this cycle
//    wrap     1               scan pointer wrapped from the last channel to 0
//    q_par    1               even parity of q (only with CHAN_MUX_PARITY_EN)
//
// Modports:
//    master  drives the lanes and controls, observes the tagged output
//    slave   the multiplexer side
//
// Optional feature macro: CHAN_MUX_PARITY_EN adds q_par.
// ---------------------------------------------------------------------------
interface chan_mux_scan_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
);
   localparam int SEL_W = $clog2(CHANNELS);

   logic [CHANNELS*WIDTH-1:0] in;
   logic [SEL_W-1:0]          sel;
   logic                      mode;
   logic                      en;
   logic [WIDTH-1:0]          q;
   logic [SEL_W-1:0]          q_ch;
   logic                      q_valid;
   logic                      wrap;
`ifdef CHAN_MUX_PARITY_EN
   logic                      q_par;
`endif

   modport master (
      output in,
      output sel,
      output mode,
      output en,
      input  q,
      input  q_ch,
      input  q_valid,
`ifdef CHAN_MUX_PARITY_EN
      input  q_par,
`endif
      input  wrap
   );

   modport slave (
      input  in,
      input  sel,
      input  mode,
      input  en,
      output q,
      output q_ch,
      output q_valid,
`ifdef CHAN_MUX_PARITY_EN
      output q_par,
`endif
      output wrap
   );

endinterface

// File: rtl/chan_mux_scan.sv
// ---------------------------------------------------------------------------
// chan_mux_scan
//
// Purpose:
//    Registered N-channel, W-bit multiplexer that feeds a single serial
//    consumer from several parallel lanes. In manual mode the channel comes
//    from an external select; in scan mode an internal round-robin pointer
//    visits every channel, staying DWELL enabled cycles on each. Every output
//    sample is tagged with its channel index and a valid flag.
//
// Parameters:
//    WIDTH     data bits per channel (>=1)
//    CHANNELS  number of channels (>=2)
//    DWELL     enabled cycles spent on each channel while scanning (>=1)
//
// Ports:
//    clk    rising-edge clock
//    rst_n  synchronous reset, active-low
//    bus    chan_mux_scan_if.slave (in, sel, mode, en -> q, q_ch, q_valid,
//           wrap, and q_par when the parity option is built)
//
// Optional feature macro: CHAN_MUX_PARITY_EN
//    When defined, q_par carries the even parity (XOR) of the sampled data,
//    registered alongside q. It is 0 after reset and for an out-of-range
//    manual select, and holds while en=0.
// ---------------------------------------------------------------------------
module chan_mux_scan #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int DWELL    = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   chan_mux_scan_if.slave bus
);

   localparam int SEL_W  = $clog2(CHANNELS);
   localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [SEL_W-1:0]  PTR_LAST  = SEL_W'(CHANNELS - 1);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);
   localparam logic [SEL_W:0]    CH_COUNT  = (SEL_W + 1)'(CHANNELS);

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_t;

   logic [SEL_W-1:0]  ptr;
   logic [DCNT_W-1:0] dcnt;
   mode_t             mode_d;

   logic              scan_start;
   logic [SEL_W-1:0]  eff_ptr;
   logic [DCNT_W-1:0] eff_dcnt;
   logic [SEL_W-1:0]  sel_idx;
   logic              sel_in_range;
   logic              sample_ok;
   logic [WIDTH-1:0]  sel_data;
   logic [WIDTH-1:0]  sample_data;
   logic              ptr_last;
   logic              dcnt_last;

   // Entering scan mode restarts the round robin: the first scan cycle
   // behaves as if ptr and dcnt were already zero, so channel 0 is sampled
   // immediately and that cycle counts as its first dwell cycle. The select
   // is widened by one bit so the range check also works when CHANNELS is
   // not a power of two.
   always_comb begin
      scan_start   = bus.mode && (mode_d == MODE_MANUAL);
      eff_ptr      = scan_start ? '0 : ptr;
      eff_dcnt     = scan_start ? '0 : dcnt;
      sel_idx      = bus.mode ? eff_ptr : bus.sel;
      sel_in_range = ({1'b0, bus.sel} < CH_COUNT);
      sample_ok    = bus.mode || sel_in_range;
      ptr_last     = (eff_ptr == PTR_LAST);
      dcnt_last    = (eff_dcnt == DCNT_LAST);
   end

   // Channel data mux written as a compare loop so an out-of-range select
   // never indexes past the flattened input bus; it simply yields zero.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (sel_idx == SEL_W'(k)) begin
            sel_data = bus.in[k*WIDTH +: WIDTH];
         end
      end
      sample_data = sample_ok ? sel_data : '0;
   end

   // All state lives here. q and q_ch are only written on enabled cycles so
   // they hold across enable gaps, while q_valid and wrap default low each
   // cycle so they behave as single-cycle strobes. mode_d tracks the mode of
   // the last enabled cycle, which is what decides a scan restart. The
   // manual branch leaves ptr and dcnt untouched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.q       <= '0;
         bus.q_ch    <= '0;
         bus.q_valid <= 1'b0;
         bus.wrap    <= 1'b0;
         ptr         <= '0;
         dcnt        <= '0;
         mode_d      <= MODE_MANUAL;
`ifdef CHAN_MUX_PARITY_EN
         bus.q_par   <= 1'b0;
`endif
      end else begin
         bus.q_valid <= 1'b0;
         bus.wrap    <= 1'b0;
         if (bus.en) begin
            mode_d      <= bus.mode ? MODE_SCAN : MODE_MANUAL;
            bus.q       <= sample_data;
            bus.q_ch    <= sel_idx;
            bus.q_valid <= sample_ok;
`ifdef CHAN_MUX_PARITY_EN
            bus.q_par   <= ^sample_data;
`endif
            if (bus.mode) begin
               if (dcnt_last) begin
                  dcnt <= '0;
                  if (ptr_last) begin
                     ptr      <= '0;
                     bus.wrap <= 1'b1;
                  end else begin
                     ptr <= eff_ptr + 1'b1;
                  end
               end else begin
                  ptr  <= eff_ptr;
                  dcnt <= eff_dcnt + 1'b1;
               end
            end
         end
      end
   end

endmodule
